// File: rtl/checker_pkg.sv
// Shared types and defaults for the chip checker control sequencer.
// Optional feature macro used by the top: CKCTRL_TIMEOUT_EN.
package checker_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    WAIT  = 3'd2,
    LOAD  = 3'd3,
    SHOW  = 3'd4
  } state_t;

  localparam int SEL_W_DEF         = 5;
  localparam int MAX_SEL_DEF       = 9;
  localparam int TICK_DIV_DEF      = 500000;
  localparam int DEB_TICKS_DEF     = 4;
  localparam int TIMEOUT_STEPS_DEF = 1024;

  function automatic bit sel_valid(
    input int unsigned sel,
    input int unsigned max_sel
  );
    return (sel >= 1) && (sel <= max_sel);
  endfunction

endpackage

// File: rtl/checker_ctrl_fsm_if.sv
// Tester-side handshake and status bundle of the checker sequencer.
// master = sequencer, slave = testers / display mux.
interface checker_ctrl_fsm_if #(
  parameter int SEL_W = checker_pkg::SEL_W_DEF
);
  logic             Check_Done;
  logic             Rslt_In;
  logic             LD_SW;
  logic             Start_Check;
  logic             LD_RSLT;
  logic             DISP_RSLT;
  logic [SEL_W-1:0] Sel_Q;
  logic             Result;
  logic             Invalid;
  logic             Timeout;

  modport master (
    input  Check_Done, Rslt_In,
    output LD_SW, Start_Check, LD_RSLT, DISP_RSLT,
    output Sel_Q, Result, Invalid, Timeout
  );

  modport slave (
    output Check_Done, Rslt_In,
    input  LD_SW, Start_Check, LD_RSLT, DISP_RSLT,
    input  Sel_Q, Result, Invalid, Timeout
  );
endinterface

// File: rtl/checker_ctrl_fsm_debouncer.sv
// Run key synchronizer + Tick-sampled debouncer.
// run_press pulses one Clk on the accepted high->low edge.
module run_debouncer #(
  parameter int DEB_TICKS = checker_pkg::DEB_TICKS_DEF
) (
  input  logic Clk,
  input  logic Reset,
  input  logic Run,
  input  logic Tick,
  output logic run_press
);
  localparam int CW = (DEB_TICKS > 1) ? $clog2(DEB_TICKS) : 1;
  localparam logic [CW-1:0] CMAX = CW'(DEB_TICKS - 1);

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q;
  logic          stable_q;
  logic          stable_d1;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      sync_q    <= 2'b11;
      cnt_q     <= '0;
      stable_q  <= 1'b1;
      stable_d1 <= 1'b1;
    end else begin
      sync_q    <= {sync_q[0], Run};
      stable_d1 <= stable_q;
      if (Tick) begin
        if (sync_q[1] == stable_q) begin
          cnt_q <= '0;
        end else if (cnt_q == CMAX) begin
          // enough consecutive samples at the new level
          stable_q <= sync_q[1];
          cnt_q    <= '0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end

  assign run_press = stable_d1 & ~stable_q;

endmodule

// File: rtl/checker_ctrl_fsm.sv
// Chip checker sequencer: slow clock divider, Run handling, test FSM.
// Define CKCTRL_TIMEOUT_EN to bound the wait for Check_Done.
module checker_ctrl_fsm
  import checker_pkg::*;
#(
  parameter int TICK_DIV      = TICK_DIV_DEF,
  parameter int SEL_W         = SEL_W_DEF,
  parameter int MAX_SEL       = MAX_SEL_DEF,
  parameter int DEB_TICKS     = DEB_TICKS_DEF,
  parameter int TIMEOUT_STEPS = TIMEOUT_STEPS_DEF
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Run,
  input  logic [SEL_W-1:0] Sel_In,
  output logic             Slow_Clk,
  output logic [2:0]       State_O,
  checker_ctrl_fsm_if.master chk
);
  localparam int DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DW-1:0] DMAX = DW'(TICK_DIV - 1);

  if (TICK_DIV < 2 || DEB_TICKS < 1 ||
      TIMEOUT_STEPS < 1 || MAX_SEL < 1) begin : g_bad_cfg
    $error("checker_ctrl_fsm: bad parameters");
  end

  logic [DW-1:0] div_q;
  logic          slow_q;
  logic          tick;
  logic          step;
  logic          run_press;
  logic          pend_q;
  logic          req;

  assign tick = (div_q == DMAX);
  assign step = tick & slow_q;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      div_q  <= '0;
      slow_q <= 1'b0;
    end else begin
      div_q  <= tick ? '0 : div_q + 1'b1;
      slow_q <= slow_q ^ tick;
    end
  end

  run_debouncer #(
    .DEB_TICKS(DEB_TICKS)
  ) u_deb (
    .Clk      (Clk),
    .Reset    (Reset),
    .Run      (Run),
    .Tick     (tick),
    .run_press(run_press)
  );

  // a press waits for the next step; every step consumes it
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) pend_q <= 1'b0;
    else        pend_q <= step ? 1'b0 : (pend_q | run_press);
  end

  assign req = pend_q | run_press;

  state_t           state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             res_q, res_d;
  logic             inv_q, inv_d;
  logic             sel_ok;

  assign sel_ok = sel_valid(32'(Sel_In), MAX_SEL);

`ifdef CKCTRL_TIMEOUT_EN
  localparam int TW = (TIMEOUT_STEPS > 1) ? $clog2(TIMEOUT_STEPS) : 1;
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_STEPS - 1);

  logic [TW-1:0] wcnt_q;
  logic          tmo_q, tmo_d;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      wcnt_q <= '0;
      tmo_q  <= 1'b0;
    end else if (step) begin
      tmo_q <= tmo_d;
      if (state_q == START)     wcnt_q <= '0;
      else if (state_q == WAIT) wcnt_q <= wcnt_q + 1'b1;
    end
  end

  assign chk.Timeout = tmo_q;
`else
  assign chk.Timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    res_d   = res_q;
    inv_d   = inv_q;
`ifdef CKCTRL_TIMEOUT_EN
    tmo_d   = tmo_q;
`endif
    unique case (state_q)
      IDLE: if (req) begin
        sel_d = Sel_In;
        if (sel_ok) begin
          inv_d   = 1'b0;
          state_d = START;
        end else begin
          inv_d   = 1'b1;
          res_d   = 1'b0;
          state_d = SHOW;
        end
      end
      START: state_d = WAIT;
      WAIT: begin
        if (chk.Check_Done) begin
          res_d   = chk.Rslt_In;
          state_d = LOAD;
        end
`ifdef CKCTRL_TIMEOUT_EN
        else if (wcnt_q == TLAST) begin
          res_d   = 1'b0;
          tmo_d   = 1'b1;
          state_d = SHOW;
        end
`endif
      end
      LOAD: state_d = SHOW;
      SHOW: if (req) begin
        res_d   = 1'b0;
        inv_d   = 1'b0;
`ifdef CKCTRL_TIMEOUT_EN
        tmo_d   = 1'b0;
`endif
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      sel_q   <= '0;
      res_q   <= 1'b0;
      inv_q   <= 1'b0;
    end else if (step) begin
      state_q <= state_d;
      sel_q   <= sel_d;
      res_q   <= res_d;
      inv_q   <= inv_d;
    end
  end

  assign Slow_Clk        = slow_q;
  assign State_O         = state_q;
  assign chk.LD_SW       = (state_q == IDLE);
  assign chk.Start_Check = (state_q == START);
  assign chk.LD_RSLT     = (state_q == LOAD);
  assign chk.DISP_RSLT   = (state_q == SHOW);
  assign chk.Sel_Q       = sel_q;
  assign chk.Result      = res_q;
  assign chk.Invalid     = inv_q;

endmodule

// File: tb/tb_checker_ctrl_fsm.sv
// Self-checking bench for checker_ctrl_fsm (TICK_DIV=4, DEB_TICKS=2).
// Covers the default build and, when defined, CKCTRL_TIMEOUT_EN.
module tb_checker_ctrl_fsm;
  localparam int NEVER = 1000;
  localparam int STEPC = 8;

  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic       Run = 1'b1;
  logic [4:0] Sel_In = '0;
  logic       Slow_Clk;
  logic [2:0] State_O;

  checker_ctrl_fsm_if #(.SEL_W(5)) bus ();

  checker_ctrl_fsm #(
    .TICK_DIV     (4),
    .SEL_W        (5),
    .MAX_SEL      (9),
    .DEB_TICKS    (2),
    .TIMEOUT_STEPS(8)
  ) dut (
    .Clk     (Clk),
    .Reset   (Reset),
    .Run     (Run),
    .Sel_In  (Sel_In),
    .Slow_Clk(Slow_Clk),
    .State_O (State_O),
    .chk     (bus)
  );

  always #5 Clk = ~Clk;

  int n_cmp = 0;
  int n_err = 0;
  int onehot_viol = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [4:0] sel;
    logic       rs;
    int         dly;
    logic       e_res;
    logic       e_inv;
    int         e_st;
    int         e_ld;
  } vec_t;

  // outcome of one test derived from the selection rules alone
  function automatic void model(input int sel, input bit rs,
                                output bit res, output bit inv,
                                output int st, output int ld);
    inv = !(sel >= 1 && sel <= 9);
    res = inv ? 1'b0 : rs;
    st  = inv ? 0 : STEPC;
    ld  = st;
  endfunction

  task automatic run_test(input logic [4:0] sel, input logic rs,
                          input int dly, input bit wpress,
                          output int st_w, output int ld_w,
                          output int wc, output bit ok);
    int show_run;
    int wp;
    int n;
    Sel_In = sel;
    bus.Rslt_In = rs;
    bus.Check_Done = 1'b0;
    st_w = 0; ld_w = 0; wc = 0; ok = 0;
    show_run = 0; wp = -1;
    for (int c = 0; c < 1500; c++) begin
      @(negedge Clk);
      if (bus.Start_Check) st_w++;
      if (bus.LD_RSLT) ld_w++;
      if (State_O == 3'd2) wc++;
      n = int'(bus.LD_SW) + int'(bus.Start_Check) +
          int'(bus.LD_RSLT) + int'(bus.DISP_RSLT);
      if (n != ((State_O == 3'd2) ? 0 : 1)) onehot_viol++;
      if (wpress && wc == 24 && wp < 0) wp = c;
      Run = (c < 24 || (wp >= 0 && c < wp + 20)) ? 1'b0 : 1'b1;
      bus.Check_Done = (State_O == 3'd1 && dly == 0) ||
                       (State_O == 3'd2 && dly < NEVER &&
                        wc >= dly * STEPC);
      if (bus.DISP_RSLT) show_run++;
      else show_run = 0;
      if (c >= 100 && show_run >= 24) begin
        ok = 1;
        break;
      end
    end
    Run = 1'b1;
  endtask

  task automatic go_idle(input string nm);
    bit ok;
    ok = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge Clk);
      Run = (c < 24) ? 1'b0 : 1'b1;
      if (c >= 48 && State_O == 3'd0) begin
        ok = 1;
        break;
      end
    end
    Run = 1'b1;
    chk({nm, ".idle_reached"}, ok, 1);
    chk({nm, ".idle_res"}, bus.Result, 0);
    chk({nm, ".idle_inv"}, bus.Invalid, 0);
    chk({nm, ".idle_tmo"}, bus.Timeout, 0);
    chk({nm, ".idle_ldsw"}, bus.LD_SW, 1);
  endtask

  task automatic check_txn(input string nm, input logic [4:0] sel,
                           input logic rs, input int dly,
                           input logic e_res, input logic e_inv,
                           input int e_st, input int e_ld);
    int st_w, ld_w, wc;
    bit ok;
    run_test(sel, rs, dly, 1'b0, st_w, ld_w, wc, ok);
    chk({nm, ".show_reached"}, ok, 1);
    chk({nm, ".state"}, State_O, 4);
    chk({nm, ".result"}, bus.Result, e_res);
    chk({nm, ".invalid"}, bus.Invalid, e_inv);
    chk({nm, ".sel_q"}, bus.Sel_Q, sel);
    chk({nm, ".timeout"}, bus.Timeout, 0);
    chk({nm, ".start_w"}, st_w, e_st);
    chk({nm, ".ldrslt_w"}, ld_w, e_ld);
    go_idle(nm);
  endtask

  vec_t tbl[6];

  initial begin
    int t0, t1, th;
    int st_w, ld_w, wc;
    bit ok, e_res, e_inv;
    int e_st, e_ld;
    logic [4:0] rsel;
    logic rrs;

    tbl[0] = '{5'd1,  1'b1, 2, 1'b1, 1'b0, 8, 8};
    tbl[1] = '{5'd9,  1'b0, 0, 1'b0, 1'b0, 8, 8};
    tbl[2] = '{5'd12, 1'b1, 1, 1'b0, 1'b1, 0, 0};
    tbl[3] = '{5'd0,  1'b1, 1, 1'b0, 1'b1, 0, 0};
    tbl[4] = '{5'd5,  1'b0, 3, 1'b0, 1'b0, 8, 8};
    tbl[5] = '{5'd10, 1'b0, 1, 1'b0, 1'b1, 0, 0};

    bus.Check_Done = 1'b0;
    bus.Rslt_In = 1'b0;
    repeat (3) @(negedge Clk);
    chk("rst.state", State_O, 0);
    chk("rst.slow", Slow_Clk, 0);
    chk("rst.ldsw", bus.LD_SW, 1);
    chk("rst.start", bus.Start_Check, 0);
    chk("rst.ldrslt", bus.LD_RSLT, 0);
    chk("rst.disp", bus.DISP_RSLT, 0);
    chk("rst.result", bus.Result, 0);
    chk("rst.invalid", bus.Invalid, 0);
    chk("rst.timeout", bus.Timeout, 0);
    chk("rst.selq", bus.Sel_Q, 0);
    Reset = 1'b1;

    t0 = -1; t1 = -1; th = -1;
    for (int c = 0; c < 100; c++) begin
      @(posedge Clk);
      #1;
      if (Slow_Clk && t0 < 0) t0 = c;
      else if (!Slow_Clk && t0 >= 0 && th < 0) th = c;
      else if (Slow_Clk && th >= 0) begin
        t1 = c;
        break;
      end
    end
    chk("slow.period", t1 - t0, 8);
    chk("slow.high", th - t0, 4);
    chk("slow.state", State_O, 0);

    @(negedge Clk);
    Run = 1'b0;
    repeat (3) @(negedge Clk);
    Run = 1'b1;
    repeat (40) @(negedge Clk);
    chk("glitch.state", State_O, 0);
    chk("glitch.ldsw", bus.LD_SW, 1);

    for (int i = 0; i < 6; i++)
      check_txn($sformatf("tbl%0d", i), tbl[i].sel, tbl[i].rs,
                tbl[i].dly, tbl[i].e_res, tbl[i].e_inv,
                tbl[i].e_st, tbl[i].e_ld);

    run_test(5'd3, 1'b1, 8, 1'b1, st_w, ld_w, wc, ok);
    chk("wpress.stays_show", ok, 1);
    chk("wpress.state", State_O, 4);
    chk("wpress.result", bus.Result, 1);
    go_idle("wpress");

`ifdef CKCTRL_TIMEOUT_EN
    run_test(5'd4, 1'b1, NEVER, 1'b0, st_w, ld_w, wc, ok);
    chk("tmo.show", ok, 1);
    chk("tmo.timeout", bus.Timeout, 1);
    chk("tmo.result", bus.Result, 0);
    chk("tmo.wait_cyc", wc, 8 * STEPC);
    chk("tmo.ldrslt", ld_w, 0);
    go_idle("tmo");
    Sel_In = 5'd2;
    ok = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge Clk);
      Run = (c < 24) ? 1'b0 : 1'b1;
      if (State_O == 3'd2) begin
        ok = 1;
        break;
      end
    end
    Run = 1'b1;
    chk("rw.reach_wait", ok, 1);
`else
    run_test(5'd4, 1'b1, NEVER, 1'b0, st_w, ld_w, wc, ok);
    chk("stuck.no_show", ok, 0);
    chk("stuck.state", State_O, 2);
    chk("stuck.steps_ge_100", wc >= 100 * STEPC, 1);
    chk("stuck.timeout", bus.Timeout, 0);
`endif

    @(negedge Clk);
    chk("rw.pre_state", State_O, 2);
    Reset = 1'b0;
    #1;
    chk("rw.state", State_O, 0);
    chk("rw.slow", Slow_Clk, 0);
    chk("rw.ldsw", bus.LD_SW, 1);
    chk("rw.disp", bus.DISP_RSLT, 0);
    chk("rw.selq", bus.Sel_Q, 0);
    repeat (2) @(negedge Clk);
    Run = 1'b1;
    Reset = 1'b1;
    repeat (16) @(negedge Clk);

    for (int i = 0; i < 6; i++) begin
      rsel = 5'($urandom_range(0, 15));
      rrs  = 1'($urandom_range(0, 1));
      model(int'(rsel), rrs, e_res, e_inv, e_st, e_ld);
      check_txn($sformatf("rnd%0d", i), rsel, rrs,
                int'($urandom_range(0, 3)), e_res, e_inv, e_st, e_ld);
    end

    chk("onehot_strobes", onehot_viol, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
